// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM / divided-clock input against
// clk_50MHz. Reports the rise-to-rise period and rise-to-fall high time in
// clock cycles, pulses meas_valid once per completed period, and raises a
// sticky timeout when no complete period arrives within 2^CNT_W-1 cycles.
//
// Ports:
//   clk_50MHz   in   system clock
//   reset       in   asynchronous active-high reset
//   pwm_in      in   asynchronous input under measurement
//   period_out  out  last period, clk cycles (rise to rise)
//   high_out    out  last high time, clk cycles (rise to fall)
//   meas_valid  out  one-cycle strobe when period_out/high_out update
//   timeout     out  sticky, cleared by the next meas_valid or reset
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise, fall;
    state_t                 state;
    logic [CNT_W-1:0]       period_cnt, high_cnt;

    // Rise and fall are both taken from the same s/s_d pair, so the
    // synchronizer latency cancels out of every measured count.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            s_d  <= sync[SYNC_STAGES-1];
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // First rise only arms the measurement; no report yet.
                    if (rise) begin
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                        state      <= HIGH;
                    end else begin
                        period_cnt <= '0;
                        high_cnt   <= '0;
                    end
                end
                HIGH: begin
                    // A rise cannot occur while s is high, so saturation
                    // here always means the input stuck high.
                    if (period_cnt == CNT_MAX) begin
                        timeout    <= 1'b1;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        state      <= IDLE;
                    end else if (fall) begin
                        period_cnt <= period_cnt + CNT_ONE;
                        state      <= LOW;
                    end else begin
                        period_cnt <= period_cnt + CNT_ONE;
                        high_cnt   <= high_cnt + CNT_ONE;
                    end
                end
                LOW: begin
                    // Rise is checked before saturation: a period of
                    // exactly CNT_MAX cycles is still a valid capture.
                    if (rise) begin
                        period_out <= period_cnt;
                        high_out   <= high_cnt;
                        meas_valid <= 1'b1;
                        timeout    <= 1'b0;
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                        state      <= HIGH;
                    end else if (period_cnt == CNT_MAX) begin
                        timeout    <= 1'b1;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        state      <= IDLE;
                    end else begin
                        period_cnt <= period_cnt + CNT_ONE;
                    end
                end
                default: begin
                    period_cnt <= '0;
                    high_cnt   <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives directed and random PWM waveforms into pwm_capture
// (CNT_W=8) and compares every cycle against a timestamp-based model:
// expected period/high are differences of observed edge times, and timeout
// is predicted from elapsed time since the last rise.
module tb_pwm_capture;

    localparam int CNT_W = 8;
    localparam int SS    = 2;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             pwm_in;
    logic [CNT_W-1:0] period_out, high_out;
    logic             meas_valid, timeout;

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .period_out(period_out),
        .high_out  (high_out),
        .meas_valid(meas_valid),
        .timeout   (timeout)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: input as seen after synchronization delay, plus times.
    bit q [0:SS];
    int cyc = 0;
    bit armed = 0;
    int last_rise = 0;
    int fall_t = 0;
    int exp_p = 0, exp_h = 0;
    bit exp_v = 0, exp_to = 0;
    int n_valid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   32'(meas_valid), 32'(exp_v));
        chk({tag, ".period"},  32'(period_out), 32'(exp_p));
        chk({tag, ".high"},    32'(high_out),   32'(exp_h));
        chk({tag, ".timeout"}, 32'(timeout),    32'(exp_to));
    endtask

    task automatic model_reset();
        for (int i = 0; i <= SS; i++) q[i] = 1'b0;
        armed  = 0;
        exp_v  = 0;
        exp_to = 0;
        exp_p  = 0;
        exp_h  = 0;
    endtask

    task automatic model_edge();
        bit cur, prev;
        cyc++;
        exp_v = 0;
        if (reset) begin
            model_reset();
            return;
        end
        cur  = q[SS-1];
        prev = q[SS];
        if (armed) begin
            if (cur && !prev) begin
                exp_v     = 1;
                exp_p     = cyc - last_rise;
                exp_h     = fall_t - last_rise;
                exp_to    = 0;
                last_rise = cyc;
                n_valid++;
            end else begin
                if (!cur && prev) fall_t = cyc;
                if (cyc - last_rise >= MAX) begin
                    exp_to = 1;
                    armed  = 0;
                end
            end
        end else if (cur && !prev) begin
            armed     = 1;
            last_rise = cyc;
        end
        for (int i = SS; i > 0; i--) q[i] = q[i-1];
        q[0] = pwm_in;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1 check_all(tag);
    endtask

    task automatic cycles(input bit v, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_in = v;
            tick(tag);
        end
    endtask

    task automatic pwm(input int h, input int l, input int reps, input string tag);
        for (int r = 0; r < reps; r++) begin
            cycles(1'b1, h, tag);
            cycles(1'b0, l, tag);
        end
    endtask

    // Called right after a tick (posedge+1): assert reset mid-cycle and
    // check the outputs clear before the next clock edge.
    task automatic do_reset(input string tag);
        #3 reset = 1'b1;
        model_reset();
        #1 check_all({tag, ".async"});
        tick({tag, ".held"});
        tick({tag, ".held"});
        #4 reset = 1'b0;
    endtask

    initial begin
        int h, l, v0;
        reset  = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        tick("por");
        tick("por");
        #4 reset = 1'b0;

        // Reset behaviour: toggling input, async reset between edges.
        pwm(3, 4, 4, "pre_rst");
        do_reset("rst1");
        pwm(5, 6, 3, "post_rst");

        // 1 MHz 50%: 25 high / 25 low.
        v0 = n_valid;
        pwm(25, 25, 5, "p50");
        chk("p50.count", 32'(n_valid - v0 >= 4), 32'd1);

        // Duty change to 10/100.
        pwm(10, 90, 3, "p100");

        // Minimum waveform: toggle every cycle.
        pwm(1, 1, 12, "min");

        // Timeout: 20/8, then hold low.
        pwm(8, 12, 3, "to_pre");
        cycles(1'b0, 300, "to_low");
        chk("to.flag", 32'(timeout), 32'd1);
        chk("to.hold_p", 32'(period_out), 32'd20);
        chk("to.hold_h", 32'(high_out), 32'd8);
        pwm(15, 25, 3, "to_resume");
        chk("resume.flag", 32'(timeout), 32'd0);

        // Boundary: period exactly MAX captures, MAX+1 times out.
        pwm(100, 155, 3, "pmax");
        pwm(100, 156, 3, "pover");
        // Stuck high.
        cycles(1'b1, 300, "stuck_hi");
        cycles(1'b0, 5, "stuck_hi");
        pwm(7, 9, 3, "after_hi");

        // Reset mid-measurement while high.
        cycles(1'b1, 14, "mid");
        do_reset("rst2");
        cycles(1'b1, 6, "mid_post");
        pwm(0, 10, 1, "mid_post");
        pwm(12, 18, 3, "mid_post");

        // Random periods, some long enough to cross the timeout boundary.
        for (int it = 0; it < 40; it++) begin
            h = $urandom_range(1, 40);
            l = $urandom_range(1, 40);
            if ($urandom_range(0, 7) == 0) l = $urandom_range(200, 300);
            pwm(h, l, 1, "rand");
        end
        pwm(4, 4, 2, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
